// File: rtl/btb_pkg.sv
// Shared types and width helpers for the set-associative branch target buffer.
package btb_pkg;

    typedef enum logic [0:0] {
        BTB_INIT,
        BTB_RUN
    } btb_state_e;

    function automatic int unsigned idx_w(input int unsigned entries, input int unsigned ways);
        return $clog2(entries / ways);
    endfunction

    function automatic int unsigned tag_w(input int unsigned pc_w, input int unsigned entries,
                                          input int unsigned ways);
        return pc_w - idx_w(entries, ways) - 2;
    endfunction

    // A direct-mapped BTB still needs a 1-bit pointer so the vector is non-empty.
    function automatic int unsigned ptr_w(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    localparam int unsigned DefPcW  = 32;
    localparam int unsigned DefTagW = tag_w(DefPcW, 256, 2);

    // Logical entry layout for the default 256-entry, 2-way, 32-bit configuration.
    typedef struct packed {
        logic               valid;
        logic [DefTagW-1:0] tag;
        logic [DefPcW-1:0]  target;
    } btb_entry_t;

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch/EX-facing bus of the BTB: lookup request, resolved-branch update, response, status.
interface btb_assoc_if #(
    parameter int unsigned PC_W = 32
);
    logic            flush;
    logic            lu_valid;
    logic [PC_W-1:0] lu_pc;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic [PC_W-1:0] upd_target;
    logic            upd_taken;
    logic            rsp_valid;
    logic            rsp_hit;
    logic [PC_W-1:0] rsp_target;
    logic            busy;

    modport master (
        output flush, lu_valid, lu_pc, upd_valid, upd_pc, upd_target, upd_taken,
        input  rsp_valid, rsp_hit, rsp_target, busy
    );

    modport slave (
        input  flush, lu_valid, lu_pc, upd_valid, upd_pc, upd_target, upd_taken,
        output rsp_valid, rsp_hit, rsp_target, busy
    );
endinterface

// File: rtl/btb_way_ram.sv
// One BTB way: synchronous-read tag/target array, flop valid vector with clear-by-index,
// plus an asynchronous probe port used by the update path.
module btb_way_ram #(
    parameter int unsigned SETS  = 128,
    parameter int unsigned IDX_W = 7,
    parameter int unsigned TAG_W = 23,
    parameter int unsigned PC_W  = 32
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [TAG_W-1:0] rd_tag,
    output logic [PC_W-1:0]  rd_target,
    output logic             rd_valid,
    input  logic [IDX_W-1:0] probe_idx,
    output logic [TAG_W-1:0] probe_tag,
    output logic             probe_valid,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [PC_W-1:0]  wr_target,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx
);
    logic [TAG_W-1:0] tag_mem    [SETS];
    logic [PC_W-1:0]  target_mem [SETS];
    logic [SETS-1:0]  valid_q;

    // Read-before-write: the registered read sees the array as it was before this edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]    <= wr_tag;
            target_mem[wr_idx] <= wr_target;
        end
        rd_tag    <= tag_mem[rd_idx];
        rd_target <= target_mem[rd_idx];
        rd_valid  <= valid_q[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (clr_en) begin
            valid_q[clr_idx] <= 1'b0;
        end
        if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    assign probe_tag   = tag_mem[probe_idx];
    assign probe_valid = valid_q[probe_idx];

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB top: init/flush sweep FSM, round-robin replacement, hit/way select.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int unsigned ENTRIES = 256,
    parameter int unsigned WAYS    = 2,
    parameter int unsigned PC_W    = 32
) (
    input logic        clk,
    input logic        rst,
    btb_assoc_if.slave bus
);
    localparam int unsigned SETS  = ENTRIES / WAYS;
    localparam int unsigned IDX_W = idx_w(ENTRIES, WAYS);
    localparam int unsigned TAG_W = tag_w(PC_W, ENTRIES, WAYS);
    localparam int unsigned PTR_W = ptr_w(WAYS);

    btb_state_e       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             sweep;
    logic             restart;

    logic [PTR_W-1:0] rr_q [SETS];

    logic [IDX_W-1:0] lu_idx, upd_idx, clr_idx;
    logic [TAG_W-1:0] lu_tag, upd_tag, lu_tag_q;
    logic             rsp_valid_q, lu_run_q;

    logic [TAG_W-1:0] rd_tag      [WAYS];
    logic [PC_W-1:0]  rd_target   [WAYS];
    logic             rd_valid    [WAYS];
    logic [TAG_W-1:0] probe_tag   [WAYS];
    logic             probe_valid [WAYS];
    logic [WAYS-1:0]  wr_en, clr_en;

    logic             upd_run, any_match, any_free, evict;
    logic [PTR_W-1:0] match_way, free_way, victim;
    int unsigned      n_match;
    logic [PC_W-1:0]  hit_target;
    logic             hit;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.lu_pc[1:0], bus.upd_pc[1:0]};

    assign restart = rst | bus.flush;
    assign lu_idx  = bus.lu_pc[IDX_W+1:2];
    assign lu_tag  = bus.lu_pc[PC_W-1:IDX_W+2];
    assign upd_idx = bus.upd_pc[IDX_W+1:2];
    assign upd_tag = bus.upd_pc[PC_W-1:IDX_W+2];

    always_ff @(posedge clk) begin
        if (restart) begin
            state_q <= BTB_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sweep   = 1'b0;
        unique case (state_q)
            BTB_INIT: begin
                sweep = 1'b1;
                if (cnt_q == IDX_W'(SETS - 1)) begin
                    state_d = BTB_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BTB_RUN: ;
            default: state_d = BTB_INIT;
        endcase
    end

    // Update path: refresh a matching way, else fill the lowest free way, else evict.
    assign upd_run = bus.upd_valid && (state_q == BTB_RUN) && !restart;

    always_comb begin
        any_match = 1'b0;
        match_way = '0;
        any_free  = 1'b0;
        free_way  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!any_match && probe_valid[w] && (probe_tag[w] == upd_tag)) begin
                any_match = 1'b1;
                match_way = PTR_W'(w);
            end
            if (!any_free && !probe_valid[w]) begin
                any_free = 1'b1;
                free_way = PTR_W'(w);
            end
        end
        victim = any_match ? match_way : (any_free ? free_way : rr_q[upd_idx]);
        evict  = upd_run && bus.upd_taken && !any_match && !any_free;
        for (int w = 0; w < WAYS; w++) begin
            wr_en[w]  = upd_run && bus.upd_taken && (victim == PTR_W'(w));
            clr_en[w] = sweep ||
                        (upd_run && !bus.upd_taken && any_match && (match_way == PTR_W'(w)));
        end
        clr_idx = sweep ? cnt_q : upd_idx;
    end

    always_ff @(posedge clk) begin
        if (sweep) begin
            rr_q[cnt_q] <= '0;
        end else if (evict) begin
            rr_q[upd_idx] <= (rr_q[upd_idx] == PTR_W'(WAYS - 1)) ? '0 : rr_q[upd_idx] + 1'b1;
        end
    end

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        btb_way_ram #(
            .SETS (SETS),
            .IDX_W(IDX_W),
            .TAG_W(TAG_W),
            .PC_W (PC_W)
        ) u_ram (
            .clk        (clk),
            .rd_idx     (lu_idx),
            .rd_tag     (rd_tag[g]),
            .rd_target  (rd_target[g]),
            .rd_valid   (rd_valid[g]),
            .probe_idx  (upd_idx),
            .probe_tag  (probe_tag[g]),
            .probe_valid(probe_valid[g]),
            .wr_en      (wr_en[g]),
            .wr_idx     (upd_idx),
            .wr_tag     (upd_tag),
            .wr_target  (bus.upd_target),
            .clr_en     (clr_en[g]),
            .clr_idx    (clr_idx)
        );
    end

    // lu_run_q captures the state at sample time, so a flush cannot cancel a lookup in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            lu_run_q    <= 1'b0;
        end else begin
            rsp_valid_q <= bus.lu_valid;
            lu_run_q    <= bus.lu_valid && (state_q == BTB_RUN);
        end
        lu_tag_q <= lu_tag;
    end

    always_comb begin
        n_match    = 0;
        hit_target = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (rd_valid[w] && (rd_tag[w] == lu_tag_q)) begin
                n_match    = n_match + 1;
                hit_target = rd_target[w];
            end
        end
        hit = lu_run_q && (n_match == 1);
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_hit    = hit;
    assign bus.rsp_target = hit ? hit_target : '0;
    assign bus.busy       = (state_q == BTB_INIT);

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc with ENTRIES=16, WAYS=2 (8 sets, index pc[4:2]).
module tb_btb_assoc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    btb_assoc_if #(.PC_W(32)) bus ();

    btb_assoc #(
        .ENTRIES(16),
        .WAYS   (2),
        .PC_W   (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rsp_chk(input string tag, input logic hit, input logic [31:0] tgt);
        chk({tag, ".valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        chk({tag, ".hit"}, {31'd0, bus.rsp_hit}, {31'd0, hit});
        chk({tag, ".target"}, bus.rsp_target, tgt);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_target = tgt;
        bus.upd_taken  = taken;
        bus.lu_valid   = 1'b0;
        step();
        bus.upd_valid  = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic [31:0] tgt);
        bus.lu_valid = 1'b1;
        bus.lu_pc    = pc;
        step();
        rsp_chk(tag, hit, tgt);
        bus.lu_valid = 1'b0;
    endtask

    initial begin
        bus.flush      = 1'b0;
        bus.lu_valid   = 1'b0;
        bus.lu_pc      = '0;
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_target = '0;
        bus.upd_taken  = 1'b0;
        step();
        step();
        chk("reset.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset.rsp_hit", {31'd0, bus.rsp_hit}, 32'd0);
        chk("reset.rsp_target", bus.rsp_target, 32'd0);
        chk("reset.busy", {31'd0, bus.busy}, 32'd1);

        // Init sweep with lookups every cycle and an update that must be dropped.
        rst            = 1'b0;
        bus.lu_valid   = 1'b1;
        bus.lu_pc      = 32'h100;
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h100;
        bus.upd_target = 32'h200;
        bus.upd_taken  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("init.busy%0d", i), {31'd0, bus.busy}, 32'd1);
            step();
            rsp_chk($sformatf("init.rsp%0d", i), 1'b0, 32'd0);
        end
        chk("init.done", {31'd0, bus.busy}, 32'd0);
        bus.upd_valid = 1'b0;
        look("init.dropped", 32'h100, 1'b0, 32'd0);

        // Install and hit.
        upd(32'h100, 32'h200, 1'b1);
        look("inst.hit", 32'h100, 1'b1, 32'h200);
        look("inst.miss104", 32'h104, 1'b0, 32'd0);
        step();
        chk("idle.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);

        // Refresh way 0, fill way 1, then evict way 0 via the pointer.
        upd(32'h100, 32'hA00, 1'b1);
        look("refresh.hit", 32'h100, 1'b1, 32'hA00);
        upd(32'h120, 32'hB00, 1'b1);
        upd(32'h140, 32'hC00, 1'b1);
        look("evict.100", 32'h100, 1'b0, 32'd0);
        look("evict.120", 32'h120, 1'b1, 32'hB00);
        look("evict.140", 32'h140, 1'b1, 32'hC00);

        // Removal frees way 1, which the next install reuses.
        upd(32'h120, 32'h0, 1'b0);
        look("remove.120", 32'h120, 1'b0, 32'd0);
        upd(32'h160, 32'hD00, 1'b1);
        look("refill.140", 32'h140, 1'b1, 32'hC00);
        look("refill.160", 32'h160, 1'b1, 32'hD00);

        // Same-cycle update and lookup; set full, pointer is 1 so 0x160 is evicted.
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h180;
        bus.upd_target = 32'hE00;
        bus.upd_taken  = 1'b1;
        bus.lu_valid   = 1'b1;
        bus.lu_pc      = 32'h180;
        step();
        bus.upd_valid = 1'b0;
        rsp_chk("hazard.same", 1'b0, 32'd0);
        step();
        rsp_chk("hazard.next", 1'b1, 32'hE00);
        look("hazard.140", 32'h140, 1'b1, 32'hC00);
        look("hazard.160", 32'h160, 1'b0, 32'd0);

        // Flush mid-stream: the lookup sampled with the flush keeps its pre-flush result.
        upd(32'h104, 32'h300, 1'b1);
        bus.lu_valid = 1'b1;
        bus.lu_pc    = 32'h140;
        step();
        rsp_chk("flush.pre", 1'b1, 32'hC00);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        rsp_chk("flush.inflight", 1'b1, 32'hC00);
        chk("flush.busy0", {31'd0, bus.busy}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            step();
            chk($sformatf("flush.busy%0d", i), {31'd0, bus.busy}, 32'd1);
            rsp_chk($sformatf("flush.rsp%0d", i), 1'b0, 32'd0);
        end
        step();
        chk("flush.done", {31'd0, bus.busy}, 32'd0);
        look("flush.104", 32'h104, 1'b0, 32'd0);
        look("flush.180", 32'h180, 1'b0, 32'd0);
        look("flush.140", 32'h140, 1'b0, 32'd0);
        upd(32'h140, 32'hC40, 1'b1);
        look("reinst.140", 32'h140, 1'b1, 32'hC40);

        // Reset mid-operation discards the in-flight response.
        bus.lu_valid = 1'b1;
        rst          = 1'b1;
        step();
        chk("rst.rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst.busy", {31'd0, bus.busy}, 32'd1);
        rst          = 1'b0;
        bus.lu_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised, set-associative branch target buffer for the fetch stage. Fetch presents the current PC each cycle and receives a registered hit/target one cycle later. The EX stage writes back resolved branches. Compared with the direct-mapped, combinational BTB it replaces, it adds per-entry valid bits, N-way associativity with round-robin replacement, removal of not-taken entries, and a sequenced init/flush sweep.

## Interface
- `ENTRIES`, default 256: total entries. Power of two, ≥ `WAYS`.
- `WAYS`, default 2: associativity, one of 1, 2 or 4.
- `PC_W`, default 32: PC and target width.
- Derived: `SETS = ENTRIES/WAYS`; `IDX_W = log2(SETS)`; `TAG_W = PC_W-IDX_W-2`.
- Index is `pc[IDX_W+1:2]`. Tag is `pc[PC_W-1:IDX_W+2]`.
- `clk` input, 1: sole clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `flush` input, 1: invalidate all entries (pulse).
- `lu_valid` input, 1: lookup request this cycle.
- `lu_pc` input, PC_W: fetch PC to look up.
- `upd_valid` input, 1: resolved-branch update this cycle.
- `upd_pc` input, PC_W: PC of the resolved branch.
- `upd_target` input, PC_W: resolved target.
- `upd_taken` input, 1: 1 = install or refresh the entry; 0 = remove the entry if present.
- `rsp_valid` output, 1: response for the lookup of the previous cycle.
- `rsp_hit` output, 1: tag match on a valid way.
- `rsp_target` output, PC_W: predicted target. 0 when `rsp_hit`=0.
- `busy` output, 1: init/flush sweep in progress.

## Operation
- FSM states: INIT and RUN.
  - INIT: a set counter `cnt` runs 0..SETS-1. Each cycle it clears the valid bits of every way in set `cnt`, and resets that set's round-robin pointer to 0.
  - INIT→RUN when `cnt`=SETS-1.
  - `rst` or `flush` forces INIT with `cnt`=0 from any state. This includes INIT itself, where it restarts the sweep.
- Lookup in RUN: read every way of set `idx(lu_pc)`. Hit when exactly one valid way has a matching tag. The next cycle drives `rsp_hit`=1 and `rsp_target` from that way.
- Lookup in INIT: still answered (`rsp_valid`=1) with `rsp_hit`=0 and `rsp_target`=0.
- Update in RUN, `upd_taken`=1:
  - On a tag match in a valid way, overwrite that way's target.
  - Otherwise allocate into the lowest-numbered invalid way.
  - If the set has no invalid way, evict the way at the set's round-robin pointer, then advance the pointer mod `WAYS`.
- Update in RUN, `upd_taken`=0: clear the valid bit of the matching way, if any. Otherwise no effect.
- Updates during INIT are dropped.
- Tag and target arrays are not reset. Only valid bits and pointers are initialised.

## Timing
- Lookup latency is 1. Inputs sampled at edge t produce `rsp_*` valid after edge t+1. `rsp_valid` equals the registered `lu_valid`.
- Lookup reads before write. A lookup in the same cycle as an update does not see that update, even for the same PC. The update is visible to lookups from the next cycle.
- Reset values: `rsp_valid`=0, `rsp_hit`=0, `rsp_target`=0, `busy`=1, state INIT, `cnt`=0.
- After `rst`/`flush` deasserts, `busy` stays high for exactly SETS cycles.
- `rst` mid-operation discards any in-flight response: `rsp_valid`=0 in the following cycle.
- `flush` does not cancel a lookup already registered. That response is delivered with its pre-flush result.

## Structure
- Package `btb_pkg` holds:
  - the state enum (`BTB_INIT`, `BTB_RUN`);
  - the index/tag/pointer width functions;
  - the entry struct {valid, tag, target}.
- Sub-module `btb_way_ram`: one instance per way via generate. Synchronous-read tag+target array plus a flop-based valid vector with a clear-by-index port.
- The top level owns the FSM, hit/way-select logic and round-robin pointers.

## Test plan
Configuration for all scenarios: `ENTRIES`=16, `WAYS`=2 (SETS=8, index `pc[4:2]`).
1. Init sweep: release `rst`, lookup 0x100 every cycle.
   - `busy`=1 for 8 cycles.
   - Every response has `rsp_valid`=1, `rsp_hit`=0.
   - An update of 0x100 issued during the sweep is dropped.
2. Install and hit: update 0x100→0x200, taken, then lookup 0x100 and 0x104.
   - 0x100 gives `rsp_hit`=1, `rsp_target`=0x200, one cycle later.
   - 0x104 gives a miss.
3. Allocation and eviction in set 0:
   - Install 0x100→0xA00, 0x120→0xB00 and 0x140→0xC00.
   - Then 0x100 misses, 0x120 hits with 0xB00, and 0x140 hits with 0xC00 (way 0 evicted, pointer now 1).
4. Removal: update 0x120 with `upd_taken`=0, then lookup, then install 0x160→0xD00.
   - 0x120 misses.
   - 0x160 goes into freed way 1; 0x140 and 0x160 both hit.
5. Same-cycle hazard: update 0x180→0xE00 and lookup 0x180 in the same cycle.
   - That response misses.
   - A lookup of 0x180 in the next cycle hits with 0xE00.
6. Flush mid-traffic: with entries installed, pulse `flush` while lookups stream.
   - `busy`=1 for 8 cycles.
   - All later lookups miss until entries are re-installed.
